// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment drivers: glyph table, blank pattern,
// DP bit position and the scan FSM state encoding.
package sseg_pkg;

    localparam logic [7:0] SEG_OFF = 8'h00;
    localparam int         DP_BIT  = 7;

    // Index n holds the g..a pattern for hex digit n; entry 15 is listed first.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_SCAN_ENC = 2'd1;
    localparam logic [1:0] ST_GAP_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_SCAN = ST_SCAN_ENC,
        ST_GAP  = ST_GAP_ENC
    } scan_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment glyph (g..a, 1 = lit).
module seg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = GLYPH_TABLE[nibble];

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with a shadow register that
// commits only at frame wrap, so a frame never shows a mix of old and new data.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int ANODE_ACT_LOW = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            load,
    input  logic [4*NUM_DIGITS-1:0]         value,
    input  logic [NUM_DIGITS-1:0]           dp_mask,
    input  logic                            blank_leading,
    output logic [7:0]                      cathode,
    output logic [NUM_DIGITS-1:0]           anode,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
    output logic                            pending,
    output logic                            frame_done,
    output scan_state_t                     dbg_state
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
        (ANODE_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    scan_state_t state, state_nxt;
    logic [PRE_W-1:0]        prescaler;
    logic [4*NUM_DIGITS-1:0] shadow_val, disp_val, upper;
    logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp, onehot, lit_anode;
    logic [7:0]              lit_cathode;
    logic [6:0]              segs;
    logic                    wrap, commit, blank, scan_lit;

    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_SCAN;
                ST_SCAN: if (prescaler == PRE_TC) state_nxt = ST_GAP;
                ST_GAP:  state_nxt = ST_SCAN;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            prescaler <= '0;
            digit_idx <= '0;
        end else begin
            state     <= state_nxt;
            prescaler <= (state == ST_SCAN && state_nxt == ST_SCAN) ? prescaler + 1'b1 : '0;
            if (!enable || state == ST_IDLE)
                digit_idx <= '0;
            else if (state == ST_GAP)
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
        end
    end

    // In IDLE nothing is on screen, so a pending load may land at once.
    assign wrap   = enable && state == ST_GAP && digit_idx == LAST_IDX;
    assign commit = pending && (state == ST_IDLE || wrap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (commit) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
            end
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_mask;
                pending    <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    // A digit is a leading zero when it and every nibble above it are zero.
    assign upper = disp_val >> {digit_idx, 2'b00};
    assign blank = blank_leading && (digit_idx != '0) && (upper == '0);

    seg_hex_decode u_dec (
        .nibble (upper[3:0]),
        .segs   (segs)
    );

    always_comb begin
        lit_cathode         = SEG_OFF;
        lit_cathode[6:0]    = blank ? 7'h00 : segs;
        lit_cathode[DP_BIT] = disp_dp[digit_idx];
    end

    assign onehot    = NUM_DIGITS'(1) << digit_idx;
    assign lit_anode = (ANODE_ACT_LOW != 0) ? ~onehot : onehot;
    assign scan_lit  = enable && state == ST_SCAN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode   <= ANODE_OFF;
            cathode <= SEG_OFF;
        end else begin
            anode   <= scan_lit ? lit_anode : ANODE_OFF;
            cathode <= scan_lit ? lit_cathode : SEG_OFF;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: directed scenarios plus random traffic, every
// cycle compared against a frame-position model of the display.
module tb_sseg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int SLOT  = DIV + 1;
    localparam int FRAME = N * SLOT;

    localparam logic [6:0] GLY [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, load, blank_leading;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [7:0]  cathode;
    logic [3:0]  anode;
    logic [1:0]  digit_idx;
    logic        pending, frame_done;
    sseg_pkg::scan_state_t dbg_state;

    int tests = 0;
    int fails = 0;

    // model: position within the frame, display/shadow contents, expected outputs
    int          m_pos;
    bit          m_run, m_pend, e_fd;
    logic [15:0] m_dv, m_sv;
    logic [3:0]  m_dd, m_sd, e_an;
    logic [7:0]  e_ca;

    sseg_scan_driver #(
        .NUM_DIGITS    (N),
        .REFRESH_DIV   (DIV),
        .ANODE_ACT_LOW (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .load          (load),
        .value         (value),
        .dp_mask       (dp_mask),
        .blank_leading (blank_leading),
        .cathode       (cathode),
        .anode         (anode),
        .digit_idx     (digit_idx),
        .pending       (pending),
        .frame_done    (frame_done),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [7:0] ref_cathode(logic [15:0] v, logic [3:0] dp, bit bl, int d);
        int h;
        logic [3:0] nib;
        logic [6:0] seg;
        h = -1;
        for (int i = 0; i < N; i++)
            if (v[4*i +: 4] != 4'h0) h = i;
        nib = v[4*d +: 4];
        seg = (bl && d > 0 && d > h) ? 7'h00 : GLY[nib];
        return {dp[d], seg};
    endfunction

    task automatic model_reset();
        m_pos = 0; m_run = 0; m_pend = 0; e_fd = 0;
        m_dv = '0; m_sv = '0; m_dd = '0; m_sd = '0;
        e_an = 4'hF; e_ca = 8'h00;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        bit lit, wrap, commit;
        int d;
        d      = m_pos / SLOT;
        lit    = enable && m_run && (m_pos % SLOT) != DIV;
        wrap   = enable && m_run && m_pos == FRAME - 1;
        commit = m_pend && (!m_run || wrap);
        e_an   = lit ? ~(4'b0001 << d) : 4'hF;
        e_ca   = lit ? ref_cathode(m_dv, m_dd, blank_leading, d) : 8'h00;
        e_fd   = wrap;
        if (commit) begin
            m_dv = m_sv;
            m_dd = m_sd;
        end
        if (load) begin
            m_sv = value; m_sd = dp_mask; m_pend = 1;
        end else if (commit) begin
            m_pend = 0;
        end
        m_pos = (enable && m_run) ? (m_pos + 1) % FRAME : 0;
        m_run = enable;
    endtask

    task automatic check_all();
        chk("anode", 32'(anode), 32'(e_an));
        chk("cathode", 32'(cathode), 32'(e_ca));
        chk("digit_idx", 32'(digit_idx), 32'(m_pos / SLOT));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic advance_to(input int p);
        for (int i = 0; i < 2 * FRAME && m_pos != p; i++) step();
    endtask

    task automatic step_to_frame_done();
        step();
        for (int i = 0; i < 2 * FRAME && !e_fd; i++) step();
    endtask

    initial begin
        int fd_cnt;
        rst = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_mask = '0; blank_leading = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_cathode", 32'(cathode), 32'h00);
        chk("rst_idx", 32'(digit_idx), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(sseg_pkg::ST_IDLE));
        rst = 1'b0;
        step();

        // first load while starting the scan: shows after the first wrap
        enable = 1'b1; load = 1'b1; value = 16'h1238; dp_mask = 4'h0;
        step();
        load = 1'b0;
        step_to_frame_done();
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin
                chk("d0_cathode_8", 32'(cathode), 32'h7F);
                chk("d0_anode", 32'(anode), 32'hE);
            end
            if (k == 5) chk("gap_anode", 32'(anode), 32'hF);
        end

        // leading-zero blanking
        blank_leading = 1'b1; load = 1'b1; value = 16'h00A5; dp_mask = 4'h0;
        step();
        load = 1'b0;
        step_to_frame_done();
        for (int k = 1; k <= FRAME; k++) begin
            step();
            if (k == 1)  chk("blank_d0_5", 32'(cathode), 32'h6D);
            if (k == 6)  chk("blank_d1_A", 32'(cathode), 32'h77);
            if (k == 11) chk("blank_d2_off", 32'(cathode), 32'h00);
            if (k == 16) chk("blank_d3_off", 32'(cathode), 32'h00);
        end

        // two loads mid-frame: last wins, frame_done every FRAME cycles
        blank_leading = 1'b0;
        advance_to(7);
        load = 1'b1; value = 16'h4321; dp_mask = 4'b0101;
        step();
        load = 1'b0;
        step(); step();
        load = 1'b1; value = 16'h9876; dp_mask = 4'b0010;
        step();
        load = 1'b0;
        fd_cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            step();
            if (frame_done) fd_cnt++;
        end
        chk("frame_done_count", 32'(fd_cnt), 32'd2);

        // load exactly on the commit cycle
        dp_mask = 4'h0;
        advance_to(8);
        load = 1'b1; value = 16'hBEEF;
        step();
        load = 1'b0;
        advance_to(FRAME - 1);
        load = 1'b1; value = 16'hC0DE;
        step();
        load = 1'b0;
        chk("commit_load_pending", 32'(pending), 32'h1);
        chk("commit_load_fd", 32'(frame_done), 32'h1);
        step();
        chk("old_shadow_shown", 32'(cathode), 32'h71);
        step_to_frame_done();
        step();
        chk("new_value_shown", 32'(cathode), 32'h79);
        chk("pending_cleared", 32'(pending), 32'h0);

        // enable drop during digit 2, then resume at digit 0
        advance_to(2 * SLOT + 1);
        enable = 1'b0;
        step();
        chk("disable_anode", 32'(anode), 32'hF);
        chk("disable_cathode", 32'(cathode), 32'h00);
        step(); step();
        enable = 1'b1;
        step(); step();
        chk("resume_anode", 32'(anode), 32'hE);
        chk("resume_idx", 32'(digit_idx), 32'h0);

        // asynchronous reset while digit 1 is scanning, with a load pending
        load = 1'b1; value = 16'h5555;
        step();
        load = 1'b0;
        advance_to(SLOT + 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_anode", 32'(anode), 32'hF);
        chk("async_rst_cathode", 32'(cathode), 32'h00);
        chk("async_rst_pending", 32'(pending), 32'h0);
        chk("async_rst_idx", 32'(digit_idx), 32'h0);
        chk("async_rst_fd", 32'(frame_done), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step_to_frame_done();
        step();
        chk("after_rst_display_zero", 32'(cathode), 32'h3F);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            enable        = ($urandom_range(0, 15) != 0);
            load          = ($urandom_range(0, 9) == 0);
            value         = 16'($urandom) >> (4 * $urandom_range(0, 3));
            dp_mask       = 4'($urandom_range(0, 15));
            blank_leading = 1'($urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
